// File: rtl/hazard_track_pkg.sv
// Shared types and constants for the hazard tracker: register-number width,
// the zero register, and the ID/EX stage record with its bubble value.
package hazard_track_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] regs;
    logic [REG_W-1:0] regt;
    logic [REG_W-1:0] regd;
    logic             regw;
    logic             memread;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{
    regs:    REG_ZERO,
    regt:    REG_ZERO,
    regd:    REG_ZERO,
    regw:    1'b0,
    memread: 1'b0
  };

endpackage

// File: rtl/hazard_track_if.sv
// Pipeline-control bus between the core (master) and the hazard tracker (slave).
interface hazard_track_if
  import hazard_track_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) ();

  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rt;
  logic [REG_W-1:0]       id_regd;
  logic                   id_regw;
  logic                   id_memread;
  logic                   flush_i;
  logic                   mem_busy_i;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic [REG_W-1:0]       idex_regs;
  logic [REG_W-1:0]       idex_regt;
  logic                   exmem_regw;
  logic [REG_W-1:0]       exmem_regd;
  logic                   memwb_regw;
  logic [REG_W-1:0]       memwb_regd;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_regd, id_regw, id_memread, flush_i, mem_busy_i,
    input  pc_write, ifid_write, ifid_flush, idex_regs, idex_regt,
           exmem_regw, exmem_regd, memwb_regw, memwb_regd, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_regd, id_regw, id_memread, flush_i, mem_busy_i,
    output pc_write, ifid_write, ifid_flush, idex_regs, idex_regt,
           exmem_regw, exmem_regd, memwb_regw, memwb_regd, stall_cnt
  );

endinterface

// File: rtl/hazard_track_pipe_wb_stage.sv
// Writeback-info stage register (regd/regw) with enable and async clear;
// used for both EX/MEM and MEM/WB.
module pipe_wb_stage
  import hazard_track_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [REG_W-1:0] regd_d,
  input  logic             regw_d,
  output logic [REG_W-1:0] regd_q,
  output logic             regw_q
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regd_q <= REG_ZERO;
      regw_q <= 1'b0;
    end else if (en_i) begin
      regd_q <= regd_d;
      regw_q <= regw_d;
    end
  end

endmodule

// File: rtl/hazard_track.sv
// Hazard tracker: holds the ID/EX, EX/MEM and MEM/WB control records, detects
// load-use hazards and drives PC / IF-ID enables under busy and flush.
module hazard_track
  import hazard_track_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  hazard_track_if.slave  bus
);

  idex_t                  idex_q;
  idex_t                  idex_d;
  logic                   advance;
  logic                   stall_inc;
  logic                   load_use;
  logic                   pc_write_c;
  logic                   ifid_write_c;
  logic                   ifid_flush_c;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [REG_W-1:0]       exmem_regd;
  logic                   exmem_regw;
  logic [REG_W-1:0]       memwb_regd;
  logic                   memwb_regw;

  // Writes to $0 never create a dependency, so a load to $0 cannot stall.
  assign load_use = idex_q.memread && (idex_q.regd != REG_ZERO) &&
                    ((idex_q.regd == bus.id_rs) || (idex_q.regd == bus.id_rt));

  // Priority: memory busy, then flush, then load-use, then normal advance.
  always_comb begin
    advance      = 1'b1;
    stall_inc    = 1'b0;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_d       = '{regs:    bus.id_rs,
                     regt:    bus.id_rt,
                     regd:    bus.id_regd,
                     regw:    bus.id_regw,
                     memread: bus.id_memread};
    if (bus.mem_busy_i) begin
      advance      = 1'b0;
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
    end else if (bus.flush_i) begin
      ifid_flush_c = 1'b1;
      idex_d       = IDEX_BUBBLE;
    end else if (load_use) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_d       = IDEX_BUBBLE;
      stall_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q <= IDEX_BUBBLE;
    end else if (advance) begin
      idex_q <= idex_d;
    end
  end

  // Saturating stall counter; only true load-use cycles count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_inc && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  pipe_wb_stage u_exmem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (advance),
    .regd_d (idex_q.regd),
    .regw_d (idex_q.regw),
    .regd_q (exmem_regd),
    .regw_q (exmem_regw)
  );

  pipe_wb_stage u_memwb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (advance),
    .regd_d (exmem_regd),
    .regw_d (exmem_regw),
    .regd_q (memwb_regd),
    .regw_q (memwb_regw)
  );

  assign bus.pc_write   = pc_write_c;
  assign bus.ifid_write = ifid_write_c;
  assign bus.ifid_flush = ifid_flush_c;
  assign bus.idex_regs  = idex_q.regs;
  assign bus.idex_regt  = idex_q.regt;
  assign bus.exmem_regd = exmem_regd;
  assign bus.exmem_regw = exmem_regw;
  assign bus.memwb_regd = memwb_regd;
  assign bus.memwb_regw = memwb_regw;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_track.sv
// Testbench for hazard_track: directed vector table, reset/saturation
// sequences and randomized traffic against an instruction-level model.
module tb_hazard_track;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_track_if #(.STALL_CNT_W(16)) bus ();
  hazard_track_if #(.STALL_CNT_W(4))  bus_s ();

  hazard_track #(.STALL_CNT_W(16)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
  hazard_track #(.STALL_CNT_W(4))  dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s));

  assign bus_s.id_rs      = bus.id_rs;
  assign bus_s.id_rt      = bus.id_rt;
  assign bus_s.id_regd    = bus.id_regd;
  assign bus_s.id_regw    = bus.id_regw;
  assign bus_s.id_memread = bus.id_memread;
  assign bus_s.flush_i    = bus.flush_i;
  assign bus_s.mem_busy_i = bus.mem_busy_i;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       w;
    logic       mr;
  } ins_t;

  typedef struct {
    ins_t       in;
    logic       fl;
    logic       busy;
    logic       e_pc;
    logic       e_ifw;
    logic       e_ifl;
    logic [4:0] e_exd;
    logic       e_exw;
    logic [4:0] e_wbd;
    logic       e_wbw;
    int         e_cnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the instruction occupying each of EX, MEM, WB, plus stall totals.
  ins_t m_ex, m_mem, m_wb;
  int   m_cnt, m_cnt_s;
  logic got_pc, got_ifw, got_ifl;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic ins_t mk_ins(input int rs, input int rt, input int rd, input bit w, input bit mr);
    ins_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.w = w; r.mr = mr;
    return r;
  endfunction

  function automatic bit hazard(input ins_t in);
    return m_ex.mr && (m_ex.rd != 5'd0) && ((m_ex.rd == in.rs) || (m_ex.rd == in.rt));
  endfunction

  task automatic model_reset();
    m_ex = ins_t'(0); m_mem = ins_t'(0); m_wb = ins_t'(0);
    m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic model_step(input ins_t in, input bit fl, input bit busy);
    bit hz;
    hz = hazard(in);
    if (!busy) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (fl || hz) ? ins_t'(0) : in;
      if (!fl && hz) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".idex_regs"},  32'(bus.idex_regs),  32'(m_ex.rs));
    chk({tag, ".idex_regt"},  32'(bus.idex_regt),  32'(m_ex.rt));
    chk({tag, ".exmem_regd"}, 32'(bus.exmem_regd), 32'(m_mem.rd));
    chk({tag, ".exmem_regw"}, 32'(bus.exmem_regw), 32'(m_mem.w));
    chk({tag, ".memwb_regd"}, 32'(bus.memwb_regd), 32'(m_wb.rd));
    chk({tag, ".memwb_regw"}, 32'(bus.memwb_regw), 32'(m_wb.w));
    chk({tag, ".stall_cnt"},  32'(bus.stall_cnt),  32'(m_cnt));
    chk({tag, ".stall_cnt_s"}, 32'(bus_s.stall_cnt), 32'(m_cnt_s));
  endtask

  task automatic drive(input ins_t in, input bit fl, input bit busy);
    bus.id_rs = in.rs; bus.id_rt = in.rt; bus.id_regd = in.rd;
    bus.id_regw = in.w; bus.id_memread = in.mr;
    bus.flush_i = fl; bus.mem_busy_i = busy;
  endtask

  // One clock: called just after a rising edge; checks comb outputs mid-cycle
  // and registered state just after the next edge.
  task automatic run_cycle(input string tag, input ins_t in, input bit fl, input bit busy);
    bit hz;
    drive(in, fl, busy);
    @(negedge clk);
    hz = hazard(in);
    got_pc = bus.pc_write; got_ifw = bus.ifid_write; got_ifl = bus.ifid_flush;
    chk({tag, ".pc_write"},   32'(got_pc),  32'(busy ? 1'b0 : (fl ? 1'b1 : !hz)));
    chk({tag, ".ifid_write"}, 32'(got_ifw), 32'(busy ? 1'b0 : (fl ? 1'b1 : !hz)));
    chk({tag, ".ifid_flush"}, 32'(got_ifl), 32'(!busy && fl));
    model_step(in, fl, busy);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  function automatic vec_t mk(input int rs, input int rt, input int rd, input bit w, input bit mr,
                              input bit fl, input bit busy, input bit pc, input bit ifw, input bit ifl,
                              input int exd, input bit exw, input int wbd, input bit wbw, input int cnt);
    vec_t v;
    v.in = mk_ins(rs, rt, rd, w, mr); v.fl = fl; v.busy = busy;
    v.e_pc = pc; v.e_ifw = ifw; v.e_ifl = ifl;
    v.e_exd = 5'(exd); v.e_exw = exw; v.e_wbd = 5'(wbd); v.e_wbw = wbw; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    // lw $8 / dependent add (stall), add $3 chain, flush+load-use, $0 load, 4-cycle busy
    vecs[0]  = mk(1, 2, 8, 1, 1, 0, 0, 1, 1, 0,  0, 0,  0, 0, 0);
    vecs[1]  = mk(8, 3, 9, 1, 0, 0, 0, 0, 0, 0,  8, 1,  0, 0, 1);
    vecs[2]  = mk(8, 3, 9, 1, 0, 0, 0, 1, 1, 0,  0, 0,  8, 1, 1);
    vecs[3]  = mk(4, 5, 3, 1, 0, 0, 0, 1, 1, 0,  9, 1,  0, 0, 1);
    vecs[4]  = mk(6, 7, 10, 1, 0, 0, 0, 1, 1, 0, 3, 1,  9, 1, 1);
    vecs[5]  = mk(1, 1, 11, 1, 0, 0, 0, 1, 1, 0, 10, 1, 3, 1, 1);
    vecs[6]  = mk(0, 0, 12, 1, 1, 0, 0, 1, 1, 0, 11, 1, 10, 1, 1);
    vecs[7]  = mk(12, 0, 13, 1, 0, 1, 0, 1, 1, 1, 12, 1, 11, 1, 1);
    vecs[8]  = mk(2, 2, 0, 1, 1, 0, 0, 1, 1, 0,  0, 0, 12, 1, 1);
    vecs[9]  = mk(0, 0, 14, 1, 0, 0, 0, 1, 1, 0, 0, 1,  0, 0, 1);
    for (int i = 10; i < 14; i++)
      vecs[i] = mk(1, 2, 15, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[14] = mk(1, 2, 15, 1, 0, 0, 0, 1, 1, 0, 14, 1, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 15, 1, 14, 1, 1);

    drive(ins_t'(0), 1'b0, 1'b0);
    model_reset();
    #3;
    chk("rst.pc_write",   32'(bus.pc_write),   32'd1);
    chk("rst.ifid_write", 32'(bus.ifid_write), 32'd1);
    chk("rst.ifid_flush", 32'(bus.ifid_flush), 32'd0);
    chk("rst.exmem_regw", 32'(bus.exmem_regw), 32'd0);
    chk("rst.stall_cnt",  32'(bus.stall_cnt),  32'd0);
    bus.mem_busy_i = 1'b1;
    #1;
    chk("rst_busy.pc_write",   32'(bus.pc_write),   32'd0);
    chk("rst_busy.ifid_write", 32'(bus.ifid_write), 32'd0);
    bus.mem_busy_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_cycle(tag, vecs[i].in, vecs[i].fl, vecs[i].busy);
      chk({tag, ".t_pc"},   32'(got_pc),  32'(vecs[i].e_pc));
      chk({tag, ".t_ifw"},  32'(got_ifw), 32'(vecs[i].e_ifw));
      chk({tag, ".t_ifl"},  32'(got_ifl), 32'(vecs[i].e_ifl));
      chk({tag, ".t_exd"},  32'(bus.exmem_regd), 32'(vecs[i].e_exd));
      chk({tag, ".t_exw"},  32'(bus.exmem_regw), 32'(vecs[i].e_exw));
      chk({tag, ".t_wbd"},  32'(bus.memwb_regd), 32'(vecs[i].e_wbd));
      chk({tag, ".t_wbw"},  32'(bus.memwb_regw), 32'(vecs[i].e_wbw));
      chk({tag, ".t_cnt"},  32'(bus.stall_cnt),  32'(vecs[i].e_cnt));
    end

    // Reset asserted between edges while a load-use stall is pending
    run_cycle("mid_lw", mk_ins(2, 3, 7, 1, 1), 1'b0, 1'b0);
    drive(mk_ins(7, 0, 9, 1, 0), 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_stall.pc_write", 32'(bus.pc_write), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.pc_write",   32'(bus.pc_write),   32'd1);
    chk("mid_rst.ifid_write", 32'(bus.ifid_write), 32'd1);
    chk("mid_rst.idex_regs",  32'(bus.idex_regs),  32'd0);
    chk("mid_rst.stall_cnt",  32'(bus.stall_cnt),  32'd0);
    chk("mid_rst.exmem_regw", 32'(bus.exmem_regw), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    model_step(mk_ins(7, 0, 9, 1, 0), 1'b0, 1'b0);
    check_regs("post_rst");
    chk("post_rst.idex_regs_is_use", 32'(bus.idex_regs), 32'd7);

    // Drive the narrow counter well past its ceiling
    for (int i = 0; i < 20; i++) begin
      run_cycle("sat_lw",  mk_ins(0, 0, 5, 1, 1), 1'b0, 1'b0);
      run_cycle("sat_use", mk_ins(5, 1, 6, 1, 0), 1'b0, 1'b0);
    end
    chk("sat.small_cnt", 32'(bus_s.stall_cnt), 32'd15);
    chk("sat.wide_cnt",  32'(bus.stall_cnt),   32'd20);

    // Randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 500; i++) begin
      ins_t in;
      bit   fl, busy;
      in   = mk_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fl   = ($urandom_range(0, 9) == 0);
      busy = ($urandom_range(0, 7) == 0);
      run_cycle("rand", in, fl, busy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
